// File: rtl/lu_pkg.sv
// Shared types for the bitwise logic unit: operation encoding and the
// occupancy states of its 2-entry output buffer.
package lu_pkg;

  localparam int LU_OP_W = 3;

  // All eight codes are defined; no reserved operations exist.
  typedef enum logic [LU_OP_W-1:0] {
    LU_NOT  = 3'b000,  // ~a (b ignored)
    LU_AND  = 3'b001,
    LU_OR   = 3'b010,
    LU_XOR  = 3'b011,
    LU_NAND = 3'b100,
    LU_NOR  = 3'b101,
    LU_XNOR = 3'b110,
    LU_ANDN = 3'b111   // a & ~b
  } lu_op_e;

  // Buffer occupancy: 0, 1 or 2 stored entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lu_state_e;

endpackage : lu_pkg

// File: rtl/lu_skid_buf.sv
// Generic 2-entry valid/ready buffer. in_ready and out_valid decode from the
// registered occupancy state only, so there is no out_ready -> in_ready path.
// Entries are delivered strictly in order; the head is always on out_data.
module lu_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  import lu_pkg::*;

  lu_state_e         r_state;
  lu_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid  & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_mem[r_rd_ptr];

  // Occupancy state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode from push/pop.
  // NOTE: the default assignment first means every path drives
  // w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (!w_push && w_pop) w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Entry storage with separate write and read pointers.
  // NOTE: the storage is reset (unusual for a memory) because the head entry
  // is directly visible on out_data, which must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

endmodule : lu_skid_buf

// File: rtl/logic_unit.sv
// Pipelined WIDTH-bit bitwise logic unit. Decodes the op combinationally and
// stores each result in a 2-entry output buffer (lu_skid_buf).
// Optional feature macro: LU_FLAGS_EN adds res_zero / res_parity, computed at
// push time and stored alongside each result.
module logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
`ifdef LU_FLAGS_EN
  ,
  output logic             res_zero,
  output logic             res_parity
`endif
);
  import lu_pkg::*;

`ifdef LU_FLAGS_EN
  localparam int DATA_W = WIDTH + 2;
`else
  localparam int DATA_W = WIDTH;
`endif

  logic [WIDTH-1:0]  w_res;
  logic [DATA_W-1:0] w_in_data;
  logic [DATA_W-1:0] w_out_data;

  // Operation decode.
  always_comb begin
    w_res = ~a;
    case (lu_op_e'(op))
      LU_NOT:  w_res = ~a;
      LU_AND:  w_res = a & b;
      LU_OR:   w_res = a | b;
      LU_XOR:  w_res = a ^ b;
      LU_NAND: w_res = ~(a & b);
      LU_NOR:  w_res = ~(a | b);
      LU_XNOR: w_res = ~(a ^ b);
      LU_ANDN: w_res = a & ~b;
      default: w_res = ~a;
    endcase
  end

`ifdef LU_FLAGS_EN
  // The "non-zero" sense is stored so that cleared storage reads back as
  // res_zero = 1, matching an all-zero res after reset.
  assign w_in_data  = {(|w_res), (^w_res), w_res};
  assign res        = w_out_data[WIDTH-1:0];
  assign res_parity = w_out_data[WIDTH];
  assign res_zero   = ~w_out_data[WIDTH+1];
`else
  assign w_in_data  = w_res;
  assign res        = w_out_data;
`endif

  lu_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

endmodule : logic_unit

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit (WIDTH=32) with a result scoreboard.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge. Build with +define+LU_FLAGS_EN to also cover the flags.
module tb_logic_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
`ifdef LU_FLAGS_EN
  logic         res_zero;
  logic         res_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  // Scoreboard entries: {zero, parity, res}.
  logic [W+1:0] sb [$];

  // All-ops table at a=CC.., b=AA..: op code and expected byte pattern.
  logic [2:0] tbl_op  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [7:0] tbl_exp [8] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'h44, 8'h33};

  always #5 clk = ~clk;

  logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
`ifdef LU_FLAGS_EN
    ,
    .res_zero  (res_zero),
    .res_parity(res_parity)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x & ~y;
    endcase
  endfunction

  // Scoreboard monitor: compare on pop, then record on push.
  always @(negedge clk) begin
    logic [W-1:0] r;
    logic [W+1:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_res", res, e[W-1:0]);
`ifdef LU_FLAGS_EN
          check("sb_parity", W'(res_parity), W'(e[W]));
          check("sb_zero", W'(res_zero), W'(e[W+1]));
`endif
        end
        n_pops++;
      end
      if (in_valid && in_ready) begin
        r = model(op, a, b);
        sb.push_back({(r == '0), (^r), r});
      end
    end
  end

  // Hold operands until accepted (bounded), then drop in_valid.
  task automatic push(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic acc;
    acc = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("push_accepted", W'(acc), W'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_res", res, '0);
`ifdef LU_FLAGS_EN
    check("rst_res_zero", W'(res_zero), W'(1));
    check("rst_res_parity", W'(res_parity), W'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NOT with one-cycle latency.
    out_ready = 1'b1;
    push(3'd0, 32'h0000_FFFF, 32'h1234_5678);
    check("not_valid", W'(out_valid), W'(1));
    check("not_res", res, 32'hFFFF_0000);

    // All eight ops, in order.
    for (int i = 0; i < 8; i++) begin
      push(tbl_op[i], 32'hCCCC_CCCC, 32'hAAAA_AAAA);
      check("allops_res", res, {4{tbl_exp[i]}});
    end
    @(posedge clk); #1;
    check("allops_drained", W'(out_valid), W'(0));

    // Back-pressure: two accepted, third held, drain 1,2,3.
    out_ready = 1'b0;
    op = 3'd2; b = '0; a = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_valid1", W'(out_valid), W'(1));
    check("bp_ready1", W'(in_ready), W'(1));
    check("bp_res1", res, 32'd1);
    a = 32'd2;
    @(posedge clk); #1;
    check("bp_full_ready", W'(in_ready), W'(0));
    check("bp_head_stable", res, 32'd1);
    a = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("bp_held_ready", W'(in_ready), W'(0));
    check("bp_held_res", res, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drain2", res, 32'd2);
    check("bp_ready_again", W'(in_ready), W'(1));
    @(posedge clk); #1;
    check("bp_drain3", res, 32'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_empty", W'(out_valid), W'(0));

    // Streaming: 16 back-to-back random operand sets.
    pops0 = n_pops;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(7, 0)); a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stream_valid", W'(out_valid), W'(1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_pops", W'(n_pops - pops0), W'(16));
    check("stream_empty", W'(out_valid), W'(0));

    // Reset while FULL discards everything.
    out_ready = 1'b0;
    push(3'd1, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    push(3'd2, 32'h0000_0001, 32'h0000_0000);
    check("rst_mid_full", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", W'(out_valid), W'(0));
    check("rst_mid_ready", W'(in_ready), W'(1));
    check("rst_mid_res", res, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_stale", W'(out_valid), W'(0));
    end
    push(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("post_rst_res", res, 32'h00F0_00F0);

`ifdef LU_FLAGS_EN
    // Flags stored with each result.
    push(3'd3, 32'h1234_5678, 32'h1234_5678);
    check("flag_xor_res", res, '0);
    check("flag_xor_zero", W'(res_zero), W'(1));
    check("flag_xor_parity", W'(res_parity), W'(0));
    push(3'd2, 32'd1, 32'd0);
    check("flag_or_zero", W'(res_zero), W'(0));
    check("flag_or_parity", W'(res_parity), W'(1));
`endif

    @(posedge clk); #1;
    check("final_sb_empty", W'(sb.size()), W'(0));
    check("final_empty", W'(out_valid), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_logic_unit
